uart_tx_feeder: RTL and testbench

UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

---
 rtl/uart_tx_feeder_if.sv | 32 +++
 rtl/uart_tx_feeder.sv | 131 +++++++++++++
 tb/tb_uart_tx_feeder.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_feeder_if.sv
// Handshake bundle between the UART register block, the TX FIFO/launcher and the transmitter.
// The slave modport is the feeder side. The master modport is the register block and transmitter side.
interface uart_tx_feeder_if #(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 8
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic              wr_en_i;
   logic [DATA_W-1:0] wr_data_i;
   logic              flush_i;
   logic              ovf_clr_i;
   logic              tx_en_i;
   logic              tx_done_i;
   logic [31:0]       tx_data_o;
   logic              start_tx_o;
   logic              full_o;
   logic              empty_o;
   logic [LW-1:0]     level_o;
   logic              overflow_o;
   logic              busy_o;

   modport master (
      output wr_en_i, wr_data_i, flush_i, ovf_clr_i, tx_en_i, tx_done_i,
      input  tx_data_o, start_tx_o, full_o, empty_o, level_o, overflow_o, busy_o
   );

   modport slave (
      input  wr_en_i, wr_data_i, flush_i, ovf_clr_i, tx_en_i, tx_done_i,
      output tx_data_o, start_tx_o, full_o, empty_o, level_o, overflow_o, busy_o
   );
endinterface

// File: rtl/uart_tx_feeder.sv
// TX FIFO plus launch FSM: buffers characters and hands them to the UART transmitter one frame at a time.
//
//   state     | meaning
//   ----------+----------------------------------------------------------------
//   IDLE      | no frame in flight; launches when enabled, data held, tx idle
//   START     | head popped into tx_data_o; start requested until tx goes busy
//   WAIT_DONE | transmitter busy with the frame; wait for its done level
module uart_tx_feeder #(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   uart_tx_feeder_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH) + 1;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START     = 2'd1,
      WAIT_DONE = 2'd2
   } state_t;

   state_t            state_q;
   logic              start_tx_q;
   logic              busy_q;
   logic [DATA_W-1:0] tx_data_q;

   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]     level_q, level_d;
   logic              full_q, empty_q;
   logic              overflow_q, overflow_d;
   logic [DATA_W-1:0] mem_q [DEPTH];

   logic              pop;
   logic              push;
   logic              drop;

   // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then.
   assign pop  = (state_q == IDLE) && bus.tx_en_i && !empty_q && bus.tx_done_i && !bus.flush_i;
   assign push = bus.wr_en_i && !bus.flush_i && (!full_q || pop);
   assign drop = bus.wr_en_i && !bus.flush_i && full_q && !pop;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      overflow_d = drop || (overflow_q && !bus.ovf_clr_i);
      if (bus.flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         full_q     <= (level_d == LW'(DEPTH));
         empty_q    <= (level_d == '0);
         overflow_q <= overflow_d;
      end
   end

   // Storage is not reset; level/pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= bus.wr_data_i;
   end

   // start_tx_o is decoded from the registered state, so it trails START by one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         start_tx_q <= 1'b0;
         busy_q     <= 1'b0;
         tx_data_q  <= '0;
      end else begin
         start_tx_q <= (state_q == START);
         case (state_q)
            IDLE: begin
               if (pop) begin
                  state_q   <= START;
                  busy_q    <= 1'b1;
                  tx_data_q <= mem_q[rd_ptr_q];
               end
            end
            START: begin
               if (!bus.tx_done_i) state_q <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (bus.tx_done_i) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.tx_data_o  = 32'(tx_data_q);
   assign bus.start_tx_o = start_tx_q;
   assign bus.full_o     = full_q;
   assign bus.empty_o    = empty_q;
   assign bus.level_o    = level_q;
   assign bus.overflow_o = overflow_q;
   assign bus.busy_o     = busy_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder: a hand-driven transmitter model with hand-computed expectations.
module tb_uart_tx_feeder;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   uart_tx_feeder_if #(.DEPTH(16), .DATA_W(8)) bus ();

   uart_tx_feeder #(.DEPTH(16), .DATA_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Transmitter model: wait for start, check the character, go busy, then return to done.
   task automatic xmit(input logic [7:0] exp, input string tag);
      int n = 0;
      while (!bus.start_tx_o && n < 50) begin
         step();
         n++;
      end
      chk({tag, "_start"}, {31'b0, bus.start_tx_o}, 32'd1);
      if (bus.start_tx_o) begin
         chk({tag, "_data"}, bus.tx_data_o, {24'b0, exp});
         bus.tx_done_i = 1'b0;
         repeat (3) step();
         bus.tx_done_i = 1'b1;
         step();
      end
   endtask

   task automatic count_starts(input int ncyc, output int cnt);
      cnt = 0;
      for (int i = 0; i < ncyc; i++) begin
         step();
         if (bus.start_tx_o) cnt++;
      end
   endtask

   task automatic push1(input logic [7:0] d);
      bus.wr_en_i   = 1'b1;
      bus.wr_data_i = d;
      step();
      bus.wr_en_i   = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_empty"}, {31'b0, bus.empty_o}, 32'd1);
      chk({tag, "_full"},  {31'b0, bus.full_o}, 32'd0);
      chk({tag, "_level"}, {27'b0, bus.level_o}, 32'd0);
      chk({tag, "_ovf"},   {31'b0, bus.overflow_o}, 32'd0);
      chk({tag, "_start"}, {31'b0, bus.start_tx_o}, 32'd0);
      chk({tag, "_busy"},  {31'b0, bus.busy_o}, 32'd0);
      chk({tag, "_data"},  bus.tx_data_o, 32'd0);
   endtask

   initial begin
      int cnt;
      bus.wr_en_i   = 1'b0;
      bus.wr_data_i = '0;
      bus.flush_i   = 1'b0;
      bus.ovf_clr_i = 1'b0;
      bus.tx_en_i   = 1'b0;
      bus.tx_done_i = 1'b1;
      repeat (3) step();
      chk_reset_outputs("rst");
      rst_n = 1'b1;
      step();

      // Single character latency and handshake
      bus.tx_en_i = 1'b1;
      push1(8'hA5);
      chk("lat_empty_n", {31'b0, bus.empty_o}, 32'd0);
      chk("lat_start_n", {31'b0, bus.start_tx_o}, 32'd0);
      step();
      chk("lat_pop_busy", {31'b0, bus.busy_o}, 32'd1);
      chk("lat_pop_data", bus.tx_data_o, 32'h000000A5);
      chk("lat_pop_start", {31'b0, bus.start_tx_o}, 32'd0);
      step();
      chk("lat_start", {31'b0, bus.start_tx_o}, 32'd1);
      bus.tx_done_i = 1'b0;
      step();
      step();
      chk("wait_start_lo", {31'b0, bus.start_tx_o}, 32'd0);
      chk("wait_busy", {31'b0, bus.busy_o}, 32'd1);
      bus.tx_done_i = 1'b1;
      step();
      chk("idle_busy", {31'b0, bus.busy_o}, 32'd0);
      chk("idle_empty", {31'b0, bus.empty_o}, 32'd1);

      // Fill, overflow, sticky flag
      bus.tx_en_i = 1'b0;
      for (int i = 0; i < 16; i++) push1(8'(i));
      chk("fill_full", {31'b0, bus.full_o}, 32'd1);
      chk("fill_level", {27'b0, bus.level_o}, 32'd16);
      chk("fill_ovf", {31'b0, bus.overflow_o}, 32'd0);
      push1(8'hFF);
      chk("ovf_set", {31'b0, bus.overflow_o}, 32'd1);
      chk("ovf_level", {27'b0, bus.level_o}, 32'd16);
      step();
      chk("ovf_sticky", {31'b0, bus.overflow_o}, 32'd1);
      bus.ovf_clr_i = 1'b1;
      step();
      bus.ovf_clr_i = 1'b0;
      chk("ovf_clr", {31'b0, bus.overflow_o}, 32'd0);
      bus.ovf_clr_i = 1'b1;
      push1(8'hEE);
      bus.ovf_clr_i = 1'b0;
      chk("ovf_set_wins", {31'b0, bus.overflow_o}, 32'd1);
      bus.ovf_clr_i = 1'b1;
      step();
      bus.ovf_clr_i = 1'b0;
      chk("ovf_clr2", {31'b0, bus.overflow_o}, 32'd0);

      // Push into full FIFO coinciding with the first pop
      bus.tx_en_i   = 1'b1;
      bus.tx_done_i = 1'b1;
      push1(8'hFF);
      chk("pp_level", {27'b0, bus.level_o}, 32'd16);
      chk("pp_ovf", {31'b0, bus.overflow_o}, 32'd0);
      chk("pp_data", bus.tx_data_o, 32'h00000000);
      for (int i = 0; i < 16; i++) xmit(8'(i), "pp_ord");
      xmit(8'hFF, "pp_last");
      step();
      chk("pp_empty", {31'b0, bus.empty_o}, 32'd1);
      chk("pp_ovf_end", {31'b0, bus.overflow_o}, 32'd0);

      // Flush during WAIT_DONE, with a push suppressed by the flush
      push1(8'h11);
      push1(8'h22);
      push1(8'h33);
      xmit_hold: begin
         int n = 0;
         while (!bus.start_tx_o && n < 20) begin step(); n++; end
      end
      chk("fl_start", {31'b0, bus.start_tx_o}, 32'd1);
      chk("fl_data0", bus.tx_data_o, 32'h00000011);
      chk("fl_level0", {27'b0, bus.level_o}, 32'd2);
      bus.tx_done_i = 1'b0;
      step();
      step();
      bus.flush_i   = 1'b1;
      bus.wr_en_i   = 1'b1;
      bus.wr_data_i = 8'h99;
      step();
      bus.flush_i = 1'b0;
      bus.wr_en_i = 1'b0;
      chk("fl_level", {27'b0, bus.level_o}, 32'd0);
      chk("fl_empty", {31'b0, bus.empty_o}, 32'd1);
      chk("fl_data", bus.tx_data_o, 32'h00000011);
      chk("fl_busy", {31'b0, bus.busy_o}, 32'd1);
      chk("fl_ovf", {31'b0, bus.overflow_o}, 32'd0);
      bus.tx_done_i = 1'b1;
      count_starts(10, cnt);
      chk("fl_no_more_start", cnt, 32'd0);
      chk("fl_idle", {31'b0, bus.busy_o}, 32'd0);

      // Asynchronous reset while in START with 5 entries left
      bus.tx_en_i = 1'b0;
      for (int i = 0; i < 6; i++) push1(8'(8'h31 + i));
      chk("rs_level6", {27'b0, bus.level_o}, 32'd6);
      bus.tx_en_i = 1'b1;
      step();
      chk("rs_level5", {27'b0, bus.level_o}, 32'd5);
      chk("rs_busy", {31'b0, bus.busy_o}, 32'd1);
      chk("rs_data", bus.tx_data_o, 32'h00000031);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("rs_async");
      step();
      rst_n = 1'b1;
      count_starts(10, cnt);
      chk("rs_no_start", cnt, 32'd0);
      chk("rs_empty", {31'b0, bus.empty_o}, 32'd1);
      push1(8'h77);
      xmit(8'h77, "rs_new");

      // Pointer wrap with level held between 1 and 3
      fork
         begin : pusher
            int sent = 0;
            int cyc = 0;
            while (sent < 40 && cyc < 2000) begin
               if (bus.level_o < 3) begin
                  bus.wr_en_i   = 1'b1;
                  bus.wr_data_i = 8'(8'h40 + sent);
                  sent++;
               end else begin
                  bus.wr_en_i = 1'b0;
               end
               step();
               cyc++;
               chk("wrap_level", (bus.level_o <= 3) ? 32'd1 : 32'd0, 32'd1);
            end
            bus.wr_en_i = 1'b0;
            chk("wrap_sent", sent, 32'd40);
         end
         begin : drainer
            for (int k = 0; k < 40; k++) xmit(8'(8'h40 + k), "wrap_ord");
         end
      join
      step();
      chk("wrap_empty", {31'b0, bus.empty_o}, 32'd1);

      $display("test done: total=%0d bad=%0d", tests, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
endmodule
